// File: rtl/debounced_edge_detector.sv
// Multi-channel synchronizer, debouncer and edge detector with mode-selected event pulses.
// Define EDGE_DET_DEBOUNCE_EN to build the per-channel debounce counters; otherwise level_db follows ff2.
module debounced_edge_detector #(
    parameter int N_CH     = 4,
    parameter int DB_LIMIT = 50000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [N_CH-1:0] level,
    input  logic [1:0]      mode,
    output logic [N_CH-1:0] level_db,
    output logic [N_CH-1:0] tick,
    output logic            any_tick
);

    typedef enum logic [1:0] {
        MODE_RISE = 2'b00,
        MODE_FALL = 2'b01,
        MODE_BOTH = 2'b10,
        MODE_NONE = 2'b11
    } mode_e;

    if (N_CH < 1 || N_CH > 32 || DB_LIMIT < 1) begin : g_bad_params
        $error("debounced_edge_detector: N_CH must be 1..32 and DB_LIMIT >= 1");
    end

    logic [N_CH-1:0] ff1;
    logic [N_CH-1:0] ff2;
    logic [N_CH-1:0] db_next;
    logic [N_CH-1:0] rise;
    logic [N_CH-1:0] fall;
    logic [N_CH-1:0] tick_next;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ff1 <= '0;
            ff2 <= '0;
        end else begin
            ff1 <= level;
            ff2 <= ff1;
        end
    end

`ifdef EDGE_DET_DEBOUNCE_EN
    localparam int CNT_W = ($clog2(DB_LIMIT + 1) < 1) ? 1 : $clog2(DB_LIMIT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_LIMIT - 1);

    logic [CNT_W-1:0] cnt      [N_CH];
    logic [CNT_W-1:0] cnt_next [N_CH];

    // A channel qualifies on the edge where ff2 has disagreed for DB_LIMIT consecutive cycles.
    always_comb begin
        // NOTE: defaults first so no path through this block leaves a value unassigned (no latches).
        db_next = level_db;
        for (int i = 0; i < N_CH; i++) begin
            cnt_next[i] = cnt[i];
            if (ff2[i] == level_db[i]) begin
                cnt_next[i] = '0;
            end else if (cnt[i] == CNT_LAST) begin
                db_next[i]  = ff2[i];
                cnt_next[i] = '0;
            end else begin
                cnt_next[i] = cnt[i] + CNT_W'(1);
            end
        end
    end

    // NOTE: the counter array is ordinary flops, not a RAM, so it is cleared by reset like any other state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt[i] <= cnt_next[i];
            end
        end
    end
`else
    always_comb begin
        db_next = ff2;
    end
`endif

    assign rise = db_next & ~level_db;
    assign fall = ~db_next & level_db;

    // mode is looked at only together with a level_db change, so changing it alone cannot tick.
    always_comb begin
        tick_next = '0;
        case (mode_e'(mode))
            MODE_RISE: tick_next = rise;
            MODE_FALL: tick_next = fall;
            MODE_BOTH: tick_next = rise | fall;
            default:   tick_next = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            level_db <= '0;
            tick     <= '0;
            any_tick <= 1'b0;
        end else begin
            level_db <= db_next;
            tick     <= tick_next;
            any_tick <= |tick_next;
        end
    end

endmodule

// File: tb/tb_debounced_edge_detector.sv
// Self-checking bench for debounced_edge_detector: directed scenarios plus a randomized run
// against a sample-history reference model; works with or without EDGE_DET_DEBOUNCE_EN.
module tb_debounced_edge_detector;

    localparam int N_CH     = 4;
    localparam int DB_LIMIT = 4;
    localparam int HMAX     = DB_LIMIT + 2;
`ifdef EDGE_DET_DEBOUNCE_EN
    localparam int LAT = DB_LIMIT + 1;
    localparam bit DEB = 1'b1;
`else
    localparam int LAT = 2;
    localparam bit DEB = 1'b0;
`endif

    logic            clk;
    logic            rst;
    logic [N_CH-1:0] level;
    logic [1:0]      mode;
    logic [N_CH-1:0] level_db;
    logic [N_CH-1:0] tick;
    logic            any_tick;

    int errors = 0;
    int checks = 0;

    // Reference model state: raw samples taken at each edge, newest at index 0.
    logic [N_CH-1:0] hist [0:HMAX];
    logic [N_CH-1:0] exp_db;
    logic [N_CH-1:0] exp_tick;
    logic            exp_any;

    debounced_edge_detector #(
        .N_CH    (N_CH),
        .DB_LIMIT(DB_LIMIT)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .level   (level),
        .mode    (mode),
        .level_db(level_db),
        .tick    (tick),
        .any_tick(any_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic model_reset();
        for (int j = 0; j <= HMAX; j++) hist[j] = '0;
        exp_db   = '0;
        exp_tick = '0;
        exp_any  = 1'b0;
    endtask

    // Debounced: level_db flips once the DB_LIMIT samples that have reached ff2 all oppose it.
    // Undebounced: level_db is the sample taken two edges earlier.
    task automatic model_edge(input logic [N_CH-1:0] lvl, input logic [1:0] md);
        logic [N_CH-1:0] new_db;
        logic [N_CH-1:0] r;
        logic [N_CH-1:0] f;
        bit all_diff;
        for (int j = HMAX; j > 0; j--) hist[j] = hist[j-1];
        hist[0] = lvl;
        new_db = exp_db;
        for (int ch = 0; ch < N_CH; ch++) begin
            if (DEB) begin
                all_diff = 1'b1;
                for (int j = 2; j <= DB_LIMIT + 1; j++)
                    if (hist[j][ch] == exp_db[ch]) all_diff = 1'b0;
                if (all_diff) new_db[ch] = ~exp_db[ch];
            end else begin
                new_db[ch] = hist[2][ch];
            end
        end
        r = new_db & ~exp_db;
        f = exp_db & ~new_db;
        case (md)
            2'b00:   exp_tick = r;
            2'b01:   exp_tick = f;
            2'b10:   exp_tick = r | f;
            default: exp_tick = '0;
        endcase
        exp_any = |exp_tick;
        exp_db  = new_db;
    endtask

    // Called at a falling edge; returns at the next falling edge with the model advanced.
    task automatic step(input logic [N_CH-1:0] lvl, input logic [1:0] md);
        level = lvl;
        mode  = md;
        @(posedge clk);
        model_edge(lvl, md);
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step('0, 2'b00);
    endtask

    task automatic test_reset();
        level = 4'b1011;
        mode  = 2'b10;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checks++;
            if (level_db !== 4'b0000 || tick !== 4'b0000 || any_tick !== 1'b0) begin
                errors++;
                $display("FAIL reset_hold cyc%0d: level_db=%b tick=%b any_tick=%b, want all 0",
                         i, level_db, tick, any_tick);
            end
        end
        level = '0;
        model_reset();
        rst = 1'b0;
        for (int i = 0; i < LAT + 2; i++) begin
            step('0, 2'b00);
            checks++;
            if (level_db !== exp_db || tick !== exp_tick || any_tick !== exp_any) begin
                errors++;
                $display("FAIL reset_release cyc%0d: got %b/%b/%b want %b/%b/%b",
                         i, level_db, tick, any_tick, exp_db, exp_tick, exp_any);
            end
        end
    endtask

    task automatic test_single_rise();
        int first = -1;
        int n_tick = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            step(4'b0001, 2'b00);
            checks++;
            if (level_db !== exp_db || tick !== exp_tick || any_tick !== exp_any) begin
                errors++;
                $display("FAIL single_rise cyc%0d: got %b/%b/%b want %b/%b/%b",
                         i, level_db, tick, any_tick, exp_db, exp_tick, exp_any);
            end
            if (tick[0] === 1'b1 && any_tick === 1'b1) begin
                n_tick++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (first != LAT || n_tick != 1) begin
            errors++;
            $display("FAIL single_rise_latency: first tick at step %0d count %0d, want step %0d count 1",
                     first, n_tick, LAT);
        end
        checks++;
        if (level_db !== 4'b0001) begin
            errors++;
            $display("FAIL single_rise_level: level_db=%b want 0001", level_db);
        end
        idle(LAT + 2);
    endtask

    task automatic test_glitch();
        int g_len = DEB ? 3 : 1;
        int n_tick = 0;
        bit seen_high = 1'b0;
        for (int i = 0; i < g_len + LAT + 4; i++) begin
            step((i < g_len) ? 4'b0010 : 4'b0000, 2'b10);
            checks++;
            if (level_db !== exp_db || tick !== exp_tick || any_tick !== exp_any) begin
                errors++;
                $display("FAIL glitch cyc%0d: got %b/%b/%b want %b/%b/%b",
                         i, level_db, tick, any_tick, exp_db, exp_tick, exp_any);
            end
            if (tick[1] === 1'b1) n_tick++;
            if (level_db[1] === 1'b1) seen_high = 1'b1;
        end
        checks++;
        if (n_tick != (DEB ? 0 : 2) || seen_high != !DEB) begin
            errors++;
            $display("FAIL glitch_result: ticks=%0d level_seen_high=%0d, want ticks=%0d level_seen_high=%0d",
                     n_tick, seen_high, DEB ? 0 : 2, !DEB);
        end
    endtask

    task automatic test_both_modes();
        logic [1:0] md;
        int n_tick;
        int n_fall;
        for (int pass = 0; pass < 2; pass++) begin
            md = (pass == 0) ? 2'b10 : 2'b01;
            n_tick = 0;
            n_fall = 0;
            for (int i = 0; i < 2 * LAT + 13; i++) begin
                step((i < LAT + 10) ? 4'b0100 : 4'b0000, md);
                checks++;
                if (level_db !== exp_db || tick !== exp_tick || any_tick !== exp_any) begin
                    errors++;
                    $display("FAIL both_modes md=%b cyc%0d: got %b/%b/%b want %b/%b/%b",
                             md, i, level_db, tick, any_tick, exp_db, exp_tick, exp_any);
                end
                if (tick[2] === 1'b1) begin
                    n_tick++;
                    if (level_db[2] === 1'b0) n_fall++;
                end
            end
            checks++;
            if (n_tick != 2 - pass || n_fall != 1) begin
                errors++;
                $display("FAIL both_modes_count md=%b: ticks=%0d falling=%0d, want ticks=%0d falling=1",
                         md, n_tick, n_fall, 2 - pass);
            end
        end
    endtask

    task automatic test_simultaneous();
        int n_all = 0;
        int n_other = 0;
        for (int i = 0; i < LAT + 3; i++) begin
            step(4'b1111, 2'b00);
            checks++;
            if (level_db !== exp_db || tick !== exp_tick || any_tick !== exp_any) begin
                errors++;
                $display("FAIL simultaneous cyc%0d: got %b/%b/%b want %b/%b/%b",
                         i, level_db, tick, any_tick, exp_db, exp_tick, exp_any);
            end
            if (tick === 4'b1111) n_all++;
            else if (tick !== 4'b0000) n_other++;
        end
        checks++;
        if (n_all != 1 || n_other != 0) begin
            errors++;
            $display("FAIL simultaneous_count: all-ones cycles=%0d partial cycles=%0d, want 1 and 0",
                     n_all, n_other);
        end
        // Mode change alone, then a full fall with ticks disabled.
        for (int i = 0; i < LAT + 6; i++) begin
            step((i < 4) ? 4'b1111 : 4'b0000, 2'b11);
            checks++;
            if (tick !== 4'b0000 || any_tick !== 1'b0 || level_db !== exp_db) begin
                errors++;
                $display("FAIL mode_none cyc%0d: tick=%b any_tick=%b level_db=%b, want 0000/0/%b",
                         i, tick, any_tick, level_db, exp_db);
            end
        end
        checks++;
        if (level_db !== 4'b0000) begin
            errors++;
            $display("FAIL mode_none_track: level_db=%b want 0000", level_db);
        end
    endtask

    task automatic test_reset_mid_count();
        int first = -1;
        int n_tick = 0;
        for (int i = 0; i < LAT - 1; i++) step(4'b1000, 2'b00);
        #2 rst = 1'b1;
        #1;
        model_reset();
        checks++;
        if (level_db !== 4'b0000 || tick !== 4'b0000 || any_tick !== 1'b0) begin
            errors++;
            $display("FAIL midreset_async: got %b/%b/%b want all 0", level_db, tick, any_tick);
        end
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (level_db !== 4'b0000 || tick !== 4'b0000 || any_tick !== 1'b0) begin
                errors++;
                $display("FAIL midreset_hold cyc%0d: got %b/%b/%b want all 0",
                         i, level_db, tick, any_tick);
            end
        end
        rst = 1'b0;
        for (int i = 0; i < LAT + 3; i++) begin
            step(4'b1000, 2'b00);
            checks++;
            if (level_db !== exp_db || tick !== exp_tick || any_tick !== exp_any) begin
                errors++;
                $display("FAIL midreset_release cyc%0d: got %b/%b/%b want %b/%b/%b",
                         i, level_db, tick, any_tick, exp_db, exp_tick, exp_any);
            end
            if (tick[3] === 1'b1) begin
                n_tick++;
                if (first < 0) first = i;
            end
        end
        checks++;
        if (n_tick != 1 || first != LAT) begin
            errors++;
            $display("FAIL midreset_tick: count=%0d first=%0d, want count=1 first=%0d",
                     n_tick, first, LAT);
        end
        idle(LAT + 2);
    endtask

    task automatic test_random();
        logic [N_CH-1:0] lvl = '0;
        logic [1:0] md = 2'b10;
        int hold [N_CH];
        for (int ch = 0; ch < N_CH; ch++) hold[ch] = 0;
        for (int i = 0; i < 400; i++) begin
            for (int ch = 0; ch < N_CH; ch++) begin
                if (hold[ch] == 0) begin
                    lvl[ch]  = 1'($urandom_range(0, 1));
                    hold[ch] = $urandom_range(1, DB_LIMIT + 3);
                end else begin
                    hold[ch]--;
                end
            end
            if ($urandom_range(0, 15) == 0) md = 2'($urandom_range(0, 3));
            step(lvl, md);
            checks++;
            if (level_db !== exp_db || tick !== exp_tick || any_tick !== exp_any) begin
                errors++;
                $display("FAIL random cyc%0d mode=%b: got %b/%b/%b want %b/%b/%b",
                         i, md, level_db, tick, any_tick, exp_db, exp_tick, exp_any);
            end
        end
    endtask

    initial begin
        rst   = 1'b1;
        level = '0;
        mode  = 2'b00;
        model_reset();
        test_reset();
        test_single_rise();
        test_glitch();
        test_both_modes();
        test_simultaneous();
        test_reset_mid_count();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
